serial_ripple_subtractor: RTL
=============================

SERIAL_RIPPLE_SUBTRACTOR -- requirements
Module: serial_ripple_subtractor

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset. No other clock or reset SHALL exist.
REQ-002 Parameter WIDTH, default 4: operand and result width in bits. Legal range is 2..32.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 D1  input  WIDTH  minuend.
REQ-006 D2  input  WIDTH  subtrahend.
REQ-007 bin  input  1  borrow-in.
REQ-008 in_valid  input  1  operands valid.
REQ-009 in_ready  output  1  block can accept operands.
REQ-010 diff  output  WIDTH  registered result, D1 - D2 - bin mod 2^WIDTH.
REQ-011 bout  output  1  registered borrow-out; 1 when D1 < D2 + bin (unsigned).
REQ-012 out_valid  output  1  diff/bout hold a new result.
REQ-013 out_ready  input  1  consumer accepts the result.

Function
REQ-014 The block SHALL compute the difference bit-serially, LSB first, one bit per clock, through a single full-subtractor cell:
- d = a ^ b ^ br
- br_next = (~a & b) | (~(a ^ b) & br)
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE. The reset state is IDLE.
REQ-016 IDLE behaviour:
- in_ready = 1, out_valid = 0.
- When in_valid & in_ready at a rising edge: capture D1, D2 and bin into internal registers, seed the borrow register with bin, clear the bit counter, and go to SHIFT.
REQ-017 SHIFT behaviour:
- in_ready = 0, out_valid = 0.
- Each edge processes bit[count], shifts d into the result shift register, updates the borrow register and increments count.
- On the edge that processes bit WIDTH-1: load diff from the completed shift register, load bout from br_next, and go to DONE.
REQ-018 DONE behaviour:
- in_ready = 0, out_valid = 1.
- When out_ready = 1 at an edge, go to IDLE.
- Otherwise hold the state, with diff and bout unchanged.
REQ-019 Latency: out_valid SHALL first be high exactly WIDTH clock cycles after the accepting edge.
REQ-020 Minimum spacing between accepts SHALL be WIDTH+2 cycles. There SHALL be no accept in the same cycle as the out_ready handshake.
REQ-021 D1, D2, bin and in_valid SHALL be ignored while in SHIFT or DONE. Operand changes during SHIFT SHALL NOT affect the result.
REQ-022 out_ready SHALL be ignored outside DONE.
REQ-023 diff and bout SHALL change only on the SHIFT-to-DONE transition or on reset. After the handshake they SHALL hold the last result.
REQ-024 The bit counter SHALL be ceil(log2(WIDTH))+1 bits wide so it cannot wrap before reaching WIDTH-1.
REQ-025 in_ready and out_valid SHALL be decoded from state only, with no combinational path from any input.

Reset
REQ-026 While rst_n = 0, asynchronously and regardless of clk, the block SHALL force:
- state = IDLE
- diff = 0, bout = 0, out_valid = 0
- internal operand, borrow and count registers = 0
REQ-027 While rst_n = 0, in_ready SHALL read 1, since it is decoded from the IDLE state.
REQ-028 Reset asserted mid-SHIFT or in DONE SHALL abort the operation. No partial result SHALL appear on diff.
REQ-029 After rst_n deasserts, the first rising edge SHALL be able to accept operands.

Verification
REQ-030 WIDTH=4, D1=9, D2=3, bin=0 -> out_valid 4 cycles after accept; diff=6, bout=0.
REQ-031 WIDTH=4, D1=3, D2=9, bin=0 -> diff=0xA, bout=1. Then D1=0, D2=0, bin=1 -> diff=0xF, bout=1. Then D1=15, D2=15, bin=0 -> diff=0, bout=0.
REQ-032 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, diff and bout stable, in_ready stays 0. Raise out_ready -> IDLE on the next edge, then accept a new operand pair.
REQ-033 Operand disturbance: change D1, D2 and pulse in_valid during SHIFT -> result matches the originally captured operands, and no second accept occurs.
REQ-034 Reset mid-SHIFT after 2 bits -> diff=0, bout=0, out_valid=0, in_ready=1 immediately. A subsequent 5-2 with bin=0 yields diff=3.
REQ-035 WIDTH=8, D1=0x00, D2=0x01, bin=0 -> diff=0xFF, bout=1, out_valid 8 cycles after accept. A randomized run against a reference model (D1 - D2 - bin) covers 1000 vectors.

Source files
------------

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial D1 - D2 - bin through one full-subtractor cell, LSB first.
// Latency WIDTH cycles from accept to out_valid; result held in DONE until out_ready, no new accept meanwhile.
module serial_ripple_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic             bin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sr;
    logic             br;
    logic [CW-1:0]    count;

    logic             a;
    logic             b;
    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] sr_next;

    // Operands shift right each cycle so the cell always sees bit 0.
    always_comb begin
        a       = a_reg[0];
        b       = b_reg[0];
        d       = a ^ b ^ br;
        br_next = (~a & b) | (~(a ^ b) & br);
        sr_next = {d, sr[WIDTH-1:1]};
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            sr    <= '0;
            br    <= 1'b0;
            count <= '0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= D1;
                        b_reg <= D2;
                        br    <= bin;
                        count <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_reg <= a_reg >> 1;
                    b_reg <= b_reg >> 1;
                    sr    <= sr_next;
                    br    <= br_next;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        diff  <= sr_next;
                        bout  <= br_next;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
